// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: operand width, immediate format selector and the
// request/response types used by the immediate encoder.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    // Instruction bits occupied by each format's immediate field
    localparam logic [31:0] IMM_MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] IMM_MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] IMM_MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] IMM_MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] IMM_MASK_J = 32'hFFFF_F000;

    typedef struct packed {
        imm_sel_t          sel;
        logic [XLEN-1:0]   imm;
        logic [31:0]       instr;
    } imm_enc_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } imm_enc_rsp_t;

    // True when v[XLEN-1:lsb] are all copies of the same bit (value fits as signed)
    function automatic logic upper_is_sext(input logic [XLEN-1:0] v, input int unsigned lsb);
        logic [XLEN-1:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: clears the format's field in the template,
// writes the (possibly truncated) immediate bits and flags unrepresentable values.
module imm_pack
    import riscv_pkg::*;
(
    input  imm_enc_req_t req_i,
    output imm_enc_rsp_t rsp_o
);

    logic [XLEN-1:0] imm;
    logic [31:0]     tmpl;

    assign imm  = req_i.imm;
    assign tmpl = req_i.instr;

    always_comb begin
        rsp_o.instr = tmpl;
        rsp_o.err   = 1'b1;
        case (req_i.sel)
            IMM_I: begin
                rsp_o.instr = (tmpl & ~IMM_MASK_I) | {imm[11:0], 20'd0};
                rsp_o.err   = !upper_is_sext(imm, 11);
            end
            IMM_S: begin
                rsp_o.instr = (tmpl & ~IMM_MASK_S) | {imm[11:5], 13'd0, imm[4:0], 7'd0};
                rsp_o.err   = !upper_is_sext(imm, 11);
            end
            IMM_B: begin
                rsp_o.instr = (tmpl & ~IMM_MASK_B)
                            | {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
                rsp_o.err   = !upper_is_sext(imm, 12) || imm[0];
            end
            IMM_U: begin
                rsp_o.instr = (tmpl & ~IMM_MASK_U) | {imm[31:12], 12'd0};
                rsp_o.err   = (imm[11:0] != 12'd0) || !upper_is_sext(imm, 31);
            end
            IMM_J: begin
                rsp_o.instr = (tmpl & ~IMM_MASK_J)
                            | {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
                rsp_o.err   = !upper_is_sext(imm, 20) || imm[0];
            end
            // Unknown selector: template passes through untouched, flagged as error
            default: begin
                rsp_o.instr = tmpl;
                rsp_o.err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 holds the request, S2 the packed
// instruction; saturating counters track delivered ok/err results.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  imm_sel_t         in_sel_i,
    input  logic [XLEN-1:0]  in_imm_i,
    input  logic [31:0]      in_instr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_instr_o,
    output logic             out_err_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] cnt_ok_o,
    output logic [CNT_W-1:0] cnt_err_o
);

    logic         s1_v_q, s1_v_d;
    imm_enc_req_t s1_req_q, s1_req_d;
    logic         s2_v_q, s2_v_d;
    imm_enc_rsp_t s2_rsp_q, s2_rsp_d;
    logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

    logic         s1_adv, s2_adv, out_fire;
    imm_enc_req_t in_req;
    imm_enc_rsp_t pack_rsp;

    assign in_req = '{sel: in_sel_i, imm: in_imm_i, instr: in_instr_i};

    imm_pack u_pack (
        .req_i (s1_req_q),
        .rsp_o (pack_rsp)
    );

    always_comb begin
        s2_adv   = !s2_v_q || out_ready_i;
        s1_adv   = !s1_v_q || s2_adv;
        out_fire = s2_v_q && out_ready_i;

        s1_v_d   = s1_adv ? in_valid_i : s1_v_q;
        s1_req_d = (s1_adv && in_valid_i) ? in_req : s1_req_q;
        s2_v_d   = s2_adv ? s1_v_q : s2_v_q;
        s2_rsp_d = (s2_adv && s1_v_q) ? pack_rsp : s2_rsp_q;

        // Clear takes priority over a same-cycle increment
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (clr_cnt_i) begin
            cnt_ok_d  = '0;
            cnt_err_d = '0;
        end else if (out_fire) begin
            if (s2_rsp_q.err) begin
                if (cnt_err_q != '1) cnt_err_d = cnt_err_q + 1'b1;
            end else begin
                if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q    <= 1'b0;
            s1_req_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_rsp_q  <= '0;
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_req_q  <= s1_req_d;
            s2_v_q    <= s2_v_d;
            s2_rsp_q  <= s2_rsp_d;
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign in_ready_o  = s1_adv;
    assign out_valid_o = s2_v_q;
    assign out_instr_o = s2_rsp_q.instr;
    assign out_err_o   = s2_rsp_q.err;
    assign cnt_ok_o    = cnt_ok_q;
    assign cnt_err_o   = cnt_err_q;

endmodule
